simd_dot_pe: RTL and testbench

//  Next-generation systolic processing element: signed SIMD multiply-accumulate with a dot-product result handshake.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/simd_lane_mult.sv | 49 ++++
 rtl/simd_dot_pe.sv | 154 +++++++++++++++
 tb/tb_simd_dot_pe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the SIMD dot-product processing element.
package pe_pkg;

  typedef enum logic [1:0] {
    SIMD_1X = 2'b00,
    SIMD_2X = 2'b01,
    SIMD_4X = 2'b10
  } simd_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // The reserved code 2'b11 falls through to a single full-width lane.
  function automatic int unsigned lanes_of(simd_mode_e mode);
    case (mode)
      SIMD_2X: return 2;
      SIMD_4X: return 4;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_mult.sv
// Combinational lane split, signed lane multipliers and lane-sum adder tree.
module simd_lane_mult
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic [1:0]           simd_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [ACC_WIDTH-1:0] psum
);

  localparam int unsigned L2 = WIDTH / 2;
  localparam int unsigned L4 = WIDTH / 4;

  logic signed [2*WIDTH-1:0]   prod1;
  logic signed [WIDTH-1:0]     prod2 [2];
  logic signed [L2-1:0]        prod4 [4];
  logic signed [ACC_WIDTH-1:0] sum1, sum2, sum4;
  logic signed [ACC_WIDTH-1:0] ext4 [4];

  // Operands are sign-extended to the product width before multiplying.
  always_comb begin
    prod1 = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
    sum1  = ACC_WIDTH'(prod1);

    sum2 = '0;
    for (int i = 0; i < 2; i++) begin
      prod2[i] = WIDTH'($signed(a[i*L2 +: L2])) * WIDTH'($signed(b[i*L2 +: L2]));
      sum2     = sum2 + ACC_WIDTH'(prod2[i]);
    end

    for (int i = 0; i < 4; i++) begin
      prod4[i] = L2'($signed(a[i*L4 +: L4])) * L2'($signed(b[i*L4 +: L4]));
      ext4[i]  = ACC_WIDTH'(prod4[i]);
    end
    sum4 = (ext4[0] + ext4[1]) + (ext4[2] + ext4[3]);
  end

  always_comb begin
    case (lanes_of(simd_mode_e'(simd_mode)))
      2:       psum = sum2;
      4:       psum = sum4;
      default: psum = sum1;
    endcase
  end

endmodule

// File: rtl/simd_dot_pe.sv
// Systolic PE: SIMD signed MAC with pass-through operands and a valid/ready dot-product result.
// Define PE_ACC_SAT_EN for saturating accumulation with a sticky res_sat flag.
module simd_dot_pe
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           simd_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic                 out_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_WIDTH-1:0] res_data,
  output logic                 res_sat,
  output logic                 busy
);

  logic [ACC_WIDTH-1:0] psum;

  simd_lane_mult #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mult (
    .simd_mode (simd_mode),
    .a         (in_a),
    .b         (in_b),
    .psum      (psum)
  );

  logic                 s1_valid_q, s1_last_q;
  logic [ACC_WIDTH-1:0] s1_psum_q;
  logic                 out_valid_q, out_last_q;
  logic [WIDTH-1:0]     out_a_q, out_b_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  acc_state_e           acc_state_q, acc_state_d;
  logic                 res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0] res_data_q, res_data_d;
  logic [ACC_WIDTH-1:0] acc_sum, acc_step;
  logic                 stall, accept, advance;

  // A finished sum cannot leave stage 1 while the result slot is occupied and not being taken.
  assign stall   = s1_valid_q & s1_last_q & res_valid_q & ~res_ready;
  assign accept  = in_valid & ~stall;
  assign advance = s1_valid_q & ~stall;
  assign acc_sum = acc_q + s1_psum_q;

`ifdef PE_ACC_SAT_EN
  localparam int unsigned        Msb    = ACC_WIDTH - 1;
  localparam logic [ACC_WIDTH-1:0] SatMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SatMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic ovf, sat_flag_q, res_sat_q;

  // Signed overflow: operands agree in sign but the sum does not.
  always_comb begin
    ovf      = (acc_q[Msb] == s1_psum_q[Msb]) && (acc_sum[Msb] != acc_q[Msb]);
    acc_step = acc_sum;
    if (ovf) acc_step = acc_q[Msb] ? SatMin : SatMax;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag_q <= 1'b0;
      res_sat_q  <= 1'b0;
    end else if (advance) begin
      if (s1_last_q) begin
        res_sat_q  <= sat_flag_q | ovf;
        sat_flag_q <= 1'b0;
      end else begin
        sat_flag_q <= sat_flag_q | ovf;
      end
    end
  end

  assign res_sat = res_sat_q;
`else
  assign acc_step = acc_sum;
  assign res_sat  = 1'b0;
`endif

  always_comb begin
    acc_state_d = acc_state_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    // A new result overrides a same-cycle dequeue, so the slot never bubbles.
    if (advance) begin
      if (s1_last_q) begin
        res_valid_d = 1'b1;
        res_data_d  = acc_step;
        acc_d       = '0;
        acc_state_d = IDLE;
      end else begin
        acc_d       = acc_step;
        acc_state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_psum_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      acc_q       <= '0;
      acc_state_q <= IDLE;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        out_a_q    <= in_a;
        out_b_q    <= in_b;
        out_last_q <= in_last;
      end
      if (!stall) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_psum_q <= psum;
          s1_last_q <= in_last;
        end
      end
      acc_q       <= acc_d;
      acc_state_q <= acc_state_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_last  = out_last_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = s1_valid_q | (acc_state_q == ACCUM) | res_valid_q;

endmodule

// File: tb/tb_simd_dot_pe.sv
// Scoreboard bench for simd_dot_pe: directed cases, randomized dots, stall, reset and a 32-bit saturation case.
module tb_simd_dot_pe;

  localparam int W  = 16;
  localparam int AW = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    simd_mode;
  logic          in_valid, in_ready, in_last;
  logic [W-1:0]  in_a, in_b, out_a, out_b;
  logic          out_valid, out_last, res_valid, res_ready, res_sat, busy;
  logic [AW-1:0] res_data;

  logic          s_valid, s_ready, s_last, s_ovalid, s_olast, s_rvalid, s_rready, s_rsat, s_busy;
  logic [W-1:0]  s_a, s_b, s_oa, s_ob;
  logic [31:0]   s_rdata;

  simd_dot_pe #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .simd_mode(simd_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid), .out_a(out_a),
    .out_b(out_b), .out_last(out_last), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_sat(res_sat), .busy(busy)
  );

  simd_dot_pe #(.WIDTH(W), .ACC_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .simd_mode(2'b00), .in_valid(s_valid), .in_ready(s_ready),
    .in_a(s_a), .in_b(s_b), .in_last(s_last), .out_valid(s_ovalid), .out_a(s_oa),
    .out_b(s_ob), .out_last(s_olast), .res_valid(s_rvalid), .res_ready(s_rready),
    .res_data(s_rdata), .res_sat(s_rsat), .busy(s_busy)
  );

  int total = 0;
  int bad   = 0;
  logic [AW-1:0]  exp_q [$];
  logic [2*W:0]   pass_q [$];
  longint         acc_m = 0;
  logic [AW-1:0]  m_exp;
  logic [2*W:0]   m_pass;
  logic           rnd_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: take lane i as a plain signed integer and sum the lane products.
  function automatic longint lane_val(input logic [W-1:0] v, input int i, input int lw);
    longint x;
    x = longint'(v >> (i * lw)) & ((64'sd1 <<< lw) - 1);
    if (x >= (64'sd1 <<< (lw - 1))) x = x - (64'sd1 <<< lw);
    return x;
  endfunction

  function automatic longint dot(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    longint s;
    n = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    s = 0;
    for (int i = 0; i < n; i++) s += lane_val(a, i, W / n) * lane_val(b, i, W / n);
    return s;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic l);
    int g;
    simd_mode = m; in_a = a; in_b = b; in_last = l; in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("accept_wait", 64'(g < 200), 1);
    @(posedge clk);
    acc_m += dot(m, a, b);
    pass_q.push_back({l, a, b});
    if (l) begin
      exp_q.push_back(AW'(acc_m));
      acc_m = 0;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || res_valid) && g < 100) begin
      @(posedge clk);
      #1 g++;
    end
    chk("drain_wait", 64'(g < 100), 1);
    res_ready = 1'b0;
  endtask

  task automatic latency_and_value(input string name, input logic [AW-1:0] want);
    @(negedge clk);
    chk({name, "_lat1"}, res_valid, 0);
    @(negedge clk);
    chk({name, "_lat2"}, res_valid, 1);
    chk(name, res_data, want);
    @(posedge clk);
    #1 drain();
  endtask

  // Monitor: compare results and pass-through words whenever the DUT presents them.
  always @(negedge clk) begin
    if (!reset) begin
      if (res_valid && res_ready) begin
        chk("res_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          m_exp = exp_q.pop_front();
          chk("res_data", res_data, m_exp);
          chk("res_sat", res_sat, 0);
        end
      end
      if (out_valid) begin
        chk("pass_expected", 64'(pass_q.size() != 0), 1);
        if (pass_q.size() != 0) begin
          m_pass = pass_q.pop_front();
          chk("pass_through", {out_last, out_a, out_b}, m_pass);
        end
      end
    end
  end

  initial begin
    int g;
    reset = 1'b1; simd_mode = 2'b00; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    res_ready = 1'b0; rnd_done = 1'b0;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; s_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {out_valid, out_last, out_a, out_b, res_valid, res_sat, busy}, 0);
    chk("rst_data", res_data, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    send(2'b00, 16'd3, -16'sd2, 1'b0);
    send(2'b00, 16'd5, 16'd4, 1'b1);
    latency_and_value("m00", 40'd14);
    send(2'b01, 16'h02FF, 16'h0304, 1'b1);
    latency_and_value("m01", 40'd2);
    send(2'b10, 16'h1234, 16'hFFFF, 1'b1);
    latency_and_value("m10", 40'hFF_FFFF_FFF6);
    send(2'b11, 16'd3, 16'd3, 1'b1);
    latency_and_value("m11", 40'd9);

    // Back-to-back one-term dots with the result slot blocked.
    send(2'b00, 16'd2, 16'd2, 1'b1);
    send(2'b00, 16'd3, 16'd3, 1'b1);
    simd_mode = 2'b00; in_a = 16'd7; in_b = 16'd7; in_last = 1'b1; in_valid = 1'b1;
    exp_q.push_back(40'd49);
    pass_q.push_back({1'b1, 16'd7, 16'd7});
    @(negedge clk);
    chk("stall_ready", in_ready, 0);
    chk("stall_res", res_data, 4);
    chk("stall_valid", res_valid, 1);
    repeat (3) @(negedge clk);
    chk("stall_hold_ab", {out_a, out_b}, {16'd3, 16'd3});
    chk("stall_ready2", in_ready, 0);
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pulse_next", res_data, 9);
    chk("pulse_stall", in_ready, 0);
    @(posedge clk);
    #1 drain();

    // Randomized dots with random consumer back-pressure.
    fork
      begin
        for (int d = 0; d < 25; d++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++)
            send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'(k == len - 1));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk);
    #1 drain();

    // Reset discards a dot in progress.
    send(2'b00, 16'd9, 16'd9, 1'b0);
    send(2'b01, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    chk("busy_accum", busy, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst2_outs", {out_valid, out_last, out_a, out_b, res_valid, res_sat, busy}, 0);
    chk("rst2_data", res_data, 0);
    chk("rst2_ready", in_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    acc_m = 0;
    send(2'b00, 16'd1, 16'd1, 1'b1);
    latency_and_value("post_rst", 40'd1);

    // 32-bit accumulator: three maximal positive products.
    s_rready = 1'b1; s_a = 16'h7FFF; s_b = 16'h7FFF; s_valid = 1'b1; s_last = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 s_last = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    g = 0;
    @(negedge clk);
    while (!s_rvalid && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("sat_wait", 64'(g < 10), 1);
`ifdef PE_ACC_SAT_EN
    chk("sat_data", s_rdata, 32'h7FFF_FFFF);
    chk("sat_flag", s_rsat, 1);
`else
    chk("wrap_data", s_rdata, 32'hBFFD_0003);
    chk("wrap_flag", s_rsat, 0);
`endif
    chk("s_pass", {s_ovalid, s_olast, s_oa, s_ob, s_ready, s_busy}, {2'b01, 32'h7FFF_7FFF, 2'b11});

    repeat (3) @(negedge clk);
    chk("end_res_q", exp_q.size(), 0);
    chk("end_pass_q", pass_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
